// File: rtl/simpson_pkg.sv
// simpson_pkg: shared FSM encoding, panel weights and default sizes for the
// Simpson polynomial integrator and its Horner evaluator.
package simpson_pkg;
  localparam int W_DEF = 16;
  localparam int DEG_DEF = 3;
  localparam int ACC_W_DEF = 48;
  localparam int SIMP_END = 2;
  localparam int SIMP_MID = 8;
  localparam int TRAP_W = 3;
  localparam int NORM = 6;
  typedef enum logic [2:0] {IDLE, CHECK, TRAP, PANEL, FIN, ERR} state_t;
  function automatic int ci_w(input int deg);
    return deg > 0 ? $clog2(deg + 1) : 1;
  endfunction
endpackage

// File: rtl/poly_horner_eval.sv
// poly_horner_eval: sequential Horner evaluation of an unsigned polynomial,
// y valid with a one-cycle eval_done pulse DEG+1 cycles after eval_start.
module poly_horner_eval import simpson_pkg::*; #(
  parameter int DEG = DEG_DEF,
  parameter int W = W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CI_W = ci_w(DEG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DEG:0][W-1:0] coef,
  input  logic [W-1:0]        x,
  input  logic                eval_start,
  output logic                eval_done,
  output logic [ACC_W-1:0]    y
);
  logic [ACC_W-1:0] acc_q, acc_d, x_q, x_d;
  logic [CI_W-1:0] cnt_q, cnt_d, idx;
  logic run_q, run_d, done_q, done_d;
  always_comb begin
    idx = cnt_q - CI_W'(1);
    acc_d = acc_q;
    x_d = x_q;
    cnt_d = cnt_q;
    run_d = run_q;
    done_d = 1'b0;
    if (eval_start) begin
      acc_d = ACC_W'(coef[DEG]);
      x_d = ACC_W'(x);
      cnt_d = CI_W'(DEG);
      run_d = DEG != 0;
      done_d = DEG == 0;
    end else if (run_q) begin
      acc_d = acc_q * x_q + ACC_W'(coef[idx]);
      cnt_d = idx;
      run_d = cnt_q != CI_W'(1);
      done_d = cnt_q == CI_W'(1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      x_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      x_q <= x_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      done_q <= done_d;
    end
  end
  assign eval_done = done_q;
  assign y = acc_q;
endmodule

// File: rtl/simpson_poly_integrator.sv
// simpson_poly_integrator: integrates an unsigned polynomial over [a,b] with unit
// step using Simpson panels plus one trapezoid for odd spans, one final divide by 6.
module simpson_poly_integrator import simpson_pkg::*; #(
  parameter int W = W_DEF,
  parameter int DEG = DEG_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CI_W = ci_w(DEG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            coef_we,
  input  logic [CI_W-1:0] coef_idx,
  input  logic [W-1:0]    coef_data,
  input  logic            start,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [W-1:0]    result,
  output logic            ovf
);
  state_t state_q, state_d;
  logic [DEG:0][W-1:0] coef_q, coef_d;
  logic [W-1:0] p_q, p_d, hi_q, hi_d, b_q, b_d, result_q, result_d, x_node, p_nx;
  logic [ACC_W-1:0] f0_q, f0_d, f1_q, f1_d, n_q, n_d, y, simp, trap, quot;
  logic [1:0] off_q, off_d, off_n;
  logic run_q, run_d, first_q, first_d, busy_q, busy_d, done_q, done_d;
  logic error_q, error_d, ovf_q, ovf_d, eval_start, eval_done, odd;

  poly_horner_eval #(.DEG(DEG), .W(W), .ACC_W(ACC_W), .CI_W(CI_W)) u_eval (
    .clk(clk),
    .rst(rst),
    .coef(coef_q),
    .x(x_node),
    .eval_start(eval_start),
    .eval_done(eval_done),
    .y(y)
  );

  // off tracks which node of the current panel/trapezoid is in the evaluator;
  // the next node is issued in the same cycle the previous one completes
  always_comb begin
    coef_d = coef_q;
    if (coef_we && !busy_q && int'(coef_idx) <= DEG) coef_d[coef_idx] = coef_data;
    odd = b_q[0] ^ p_q[0];
    p_nx = p_q + W'(2);
    simp = ACC_W'(SIMP_END) * (f0_q + y) + ACC_W'(SIMP_MID) * f1_q;
    trap = ACC_W'(TRAP_W) * (f1_q + y);
    state_d = state_q;
    p_d = p_q;
    hi_d = hi_q;
    b_d = b_q;
    f0_d = f0_q;
    f1_d = f1_q;
    n_d = n_q;
    off_d = off_q;
    off_n = off_q;
    run_d = run_q;
    first_d = first_q;
    eval_start = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = CHECK;
        p_d = a;
        b_d = b;
        n_d = '0;
        first_d = 1'b1;
        run_d = 1'b0;
      end
      CHECK: begin
        hi_d = odd ? b_q - W'(1) : b_q;
        state_d = p_q >= b_q ? ERR : odd ? TRAP : PANEL;
      end
      TRAP: begin
        if (eval_done && off_q == 2'd0) f1_d = y;
        if (!run_q || (eval_done && off_q == 2'd0)) begin
          eval_start = 1'b1;
          off_n = {1'b0, run_q};
          off_d = off_n;
          run_d = 1'b1;
        end else if (eval_done) begin
          n_d = n_q + trap;
          run_d = 1'b0;
          state_d = p_q == hi_q ? FIN : PANEL;
        end
      end
      PANEL: begin
        if (eval_done && off_q == 2'd0) f0_d = y;
        if (eval_done && off_q == 2'd1) f1_d = y;
        if (!run_q || (eval_done && off_q != 2'd2)) begin
          eval_start = 1'b1;
          off_n = !run_q ? {1'b0, !first_q} : off_q + 2'd1;
          off_d = off_n;
          run_d = 1'b1;
        end else if (eval_done) begin
          n_d = n_q + simp;
          f0_d = y;
          first_d = 1'b0;
          p_d = p_nx;
          run_d = 1'b0;
          state_d = p_nx == hi_q ? FIN : PANEL;
        end
      end
      default: state_d = IDLE;
    endcase
    x_node = (state_q == TRAP ? b_q - W'(1) : p_q) + W'(off_n);
    quot = n_d / ACC_W'(NORM);
    busy_d = state_d != IDLE;
    done_d = state_d == FIN;
    error_d = state_d == ERR;
    result_d = done_d ? quot[W-1:0] : result_q;
    ovf_d = done_d ? |(quot >> W) : ovf_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      coef_q <= '0;
      p_q <= '0;
      hi_q <= '0;
      b_q <= '0;
      f0_q <= '0;
      f1_q <= '0;
      n_q <= '0;
      off_q <= '0;
      run_q <= 1'b0;
      first_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
      result_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      coef_q <= coef_d;
      p_q <= p_d;
      hi_q <= hi_d;
      b_q <= b_d;
      f0_q <= f0_d;
      f1_q <= f1_d;
      n_q <= n_d;
      off_q <= off_d;
      run_q <= run_d;
      first_q <= first_d;
      busy_q <= busy_d;
      done_q <= done_d;
      error_q <= error_d;
      result_q <= result_d;
      ovf_q <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign error = error_q;
  assign result = result_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_simpson_poly_integrator.sv
// tb_simpson_poly_integrator: scenario tasks with a scoreboard of expected
// results built from a direct power-sum model of the integrand.
module tb_simpson_poly_integrator;
  localparam int W = 16, DEG = 3, ACC_W = 48, CI_W = 2;
  typedef struct {logic err; logic [W-1:0] res; logic ovf;} exp_t;
  logic clk = 1'b0, rst = 1'b1, coef_we = 1'b0, start = 1'b0;
  logic [CI_W-1:0] coef_idx = '0;
  logic [W-1:0] coef_data = '0, a = '0, b = '0;
  logic busy, done, error, ovf;
  logic [W-1:0] result;
  exp_t sb[$];
  logic [W-1:0] mc [DEG+1];
  logic [W-1:0] m_res = '0;
  logic m_ovf = 1'b0;
  int n_vec = 0, n_bad = 0, n_es = 0;

  simpson_poly_integrator dut (
    .clk(clk), .rst(rst), .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data),
    .start(start), .a(a), .b(b), .busy(busy), .done(done), .error(error),
    .result(result), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (dut.eval_start) n_es++;

  function automatic logic [ACC_W-1:0] fx(input int x);
    logic [ACC_W-1:0] s, pw;
    s = '0;
    pw = ACC_W'(1);
    for (int i = 0; i <= DEG; i++) begin
      s = s + ACC_W'(mc[i]) * pw;
      pw = pw * ACC_W'(x);
    end
    return s;
  endfunction

  task automatic push_expect(input logic [W-1:0] la, input logic [W-1:0] lb);
    logic [ACC_W-1:0] n, q;
    exp_t ex;
    int hi;
    ex.err = la >= lb;
    if (!ex.err) begin
      n = '0;
      hi = int'(lb);
      if ((int'(lb) - int'(la)) % 2 == 1) begin
        n = n + ACC_W'(3) * (fx(hi - 1) + fx(hi));
        hi--;
      end
      for (int p = int'(la); p < hi; p += 2) n = n + ACC_W'(2) * (fx(p) + ACC_W'(4) * fx(p + 1) + fx(p + 2));
      q = n / ACC_W'(6);
      m_res = q[W-1:0];
      m_ovf = |q[ACC_W-1:W];
    end
    ex.res = m_res;
    ex.ovf = m_ovf;
    sb.push_back(ex);
  endtask

  task automatic set_coef(input int i, input logic [W-1:0] v);
    coef_we = 1'b1;
    coef_idx = CI_W'(i);
    coef_data = v;
    @(negedge clk);
    coef_we = 1'b0;
    mc[i] = v;
  endtask

  task automatic clear_model();
    for (int i = 0; i <= DEG; i++) mc[i] = '0;
  endtask

  task automatic launch(input logic [W-1:0] la, input logic [W-1:0] lb);
    a = la;
    b = lb;
    start = 1'b1;
    push_expect(la, lb);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_out(output int cyc, output logic d, output logic e);
    cyc = 1;
    d = done;
    e = error;
    while (!d && !e && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      d = done;
      e = error;
    end
  endtask

  task automatic test_reset();
    clear_model();
    repeat (2) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0 || error !== 1'b0) begin n_bad++; $display("FAIL reset_pulses: got %b%b want 00", done, error); end
    n_vec++; if (result !== '0 || ovf !== 1'b0) begin n_bad++; $display("FAIL reset_result: got %h/%b want 0/0", result, ovf); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_linear();
    int cyc, es0;
    logic d, e;
    exp_t ex;
    set_coef(1, 16'd1);
    es0 = n_es;
    launch(16'd0, 16'd2);
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL lin_busy: got %b want 1", busy); end
    wait_out(cyc, d, e);
    ex = sb.pop_front();
    n_vec++; if (d !== 1'b1) begin n_bad++; $display("FAIL lin_done: got %b want 1", d); end
    n_vec++; if (result !== ex.res || result !== 16'd2) begin n_bad++; $display("FAIL lin_result: got %0d want %0d", result, ex.res); end
    n_vec++; if (ovf !== ex.ovf) begin n_bad++; $display("FAIL lin_ovf: got %b want %b", ovf, ex.ovf); end
    n_vec++; if (cyc !== 15) begin n_bad++; $display("FAIL lin_latency: got %0d want 15", cyc); end
    n_vec++; if (n_es - es0 !== 3) begin n_bad++; $display("FAIL lin_evals: got %0d want 3", n_es - es0); end
    @(negedge clk);
    n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL lin_pulse: got done %b busy %b want 0 0", done, busy); end
  endtask

  task automatic test_odd();
    int cyc;
    logic d, e;
    exp_t ex;
    set_coef(1, 16'd0);
    set_coef(2, 16'd1);
    launch(16'd0, 16'd3);
    wait_out(cyc, d, e);
    ex = sb.pop_front();
    n_vec++; if (d !== 1'b1 || result !== ex.res || result !== 16'd9) begin n_bad++; $display("FAIL odd_result: got %b/%0d want 1/%0d", d, result, ex.res); end
    n_vec++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL odd_ovf: got %b want 0", ovf); end
    n_vec++; if (cyc !== 24) begin n_bad++; $display("FAIL odd_latency: got %0d want 24", cyc); end
    @(negedge clk);
  endtask

  task automatic test_trap_reuse();
    int cyc, es0;
    logic d, e;
    exp_t ex;
    set_coef(2, 16'd0);
    set_coef(0, 16'd5);
    es0 = n_es;
    launch(16'd10, 16'd11);
    wait_out(cyc, d, e);
    ex = sb.pop_front();
    n_vec++; if (d !== 1'b1 || result !== ex.res || result !== 16'd5) begin n_bad++; $display("FAIL trap_result: got %b/%0d want 1/%0d", d, result, ex.res); end
    n_vec++; if (n_es - es0 !== 2) begin n_bad++; $display("FAIL trap_evals: got %0d want 2", n_es - es0); end
    @(negedge clk);
    es0 = n_es;
    launch(16'd10, 16'd14);
    wait_out(cyc, d, e);
    ex = sb.pop_front();
    n_vec++; if (d !== 1'b1 || result !== ex.res || result !== 16'd20) begin n_bad++; $display("FAIL reuse_result: got %b/%0d want 1/%0d", d, result, ex.res); end
    n_vec++; if (n_es - es0 !== 5) begin n_bad++; $display("FAIL reuse_evals: got %0d want 5", n_es - es0); end
    n_vec++; if (cyc !== 24) begin n_bad++; $display("FAIL reuse_latency: got %0d want 24", cyc); end
    @(negedge clk);
  endtask

  task automatic test_error();
    int cyc;
    logic d, e;
    exp_t ex;
    logic [W-1:0] la [2];
    logic [W-1:0] lb [2];
    la[0] = 16'd4; lb[0] = 16'd4;
    la[1] = 16'd7; lb[1] = 16'd3;
    for (int i = 0; i < 2; i++) begin
      launch(la[i], lb[i]);
      wait_out(cyc, d, e);
      ex = sb.pop_front();
      n_vec++; if (e !== ex.err || d !== 1'b0) begin n_bad++; $display("FAIL err%0d_pulse: got err %b done %b want 1 0", i, e, d); end
      n_vec++; if (result !== ex.res || ovf !== ex.ovf) begin n_bad++; $display("FAIL err%0d_hold: got %0d/%b want %0d/%b", i, result, ovf, ex.res, ex.ovf); end
      @(negedge clk);
      n_vec++; if (busy !== 1'b0 || error !== 1'b0) begin n_bad++; $display("FAIL err%0d_idle: got busy %b err %b want 0 0", i, busy, error); end
    end
  endtask

  task automatic test_ovf();
    int cyc;
    logic d, e;
    exp_t ex;
    coef_we = 1'b1;
    coef_idx = 2'd0;
    coef_data = 16'hFFFF;
    mc[0] = 16'hFFFF;
    launch(16'd0, 16'd2);
    coef_we = 1'b0;
    wait_out(cyc, d, e);
    ex = sb.pop_front();
    n_vec++; if (d !== 1'b1 || result !== ex.res || result !== 16'hFFFE) begin n_bad++; $display("FAIL ovf_result: got %b/%h want 1/%h", d, result, ex.res); end
    n_vec++; if (ovf !== ex.ovf || ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", ovf); end
    @(negedge clk);
  endtask

  task automatic test_max_limit();
    int cyc;
    logic d, e;
    exp_t ex;
    logic [W-1:0] la [2];
    la[0] = 16'hFFFD;
    la[1] = 16'hFFFE;
    set_coef(0, 16'd0);
    set_coef(1, 16'd1);
    for (int i = 0; i < 2; i++) begin
      launch(la[i], 16'hFFFF);
      wait_out(cyc, d, e);
      ex = sb.pop_front();
      n_vec++; if (d !== 1'b1 || result !== ex.res || ovf !== ex.ovf) begin n_bad++; $display("FAIL max%0d: got %b/%h/%b want 1/%h/%b", i, d, result, ovf, ex.res, ex.ovf); end
      @(negedge clk);
    end
  endtask

  task automatic test_busy_ignore();
    int cyc, extra;
    logic d, e;
    exp_t ex;
    launch(16'd0, 16'd2);
    coef_we = 1'b1;
    coef_idx = 2'd0;
    coef_data = 16'd7;
    a = 16'd0;
    b = 16'd4;
    start = 1'b1;
    @(negedge clk);
    coef_we = 1'b0;
    start = 1'b0;
    wait_out(cyc, d, e);
    ex = sb.pop_front();
    n_vec++; if (d !== 1'b1 || result !== ex.res || result !== 16'd2) begin n_bad++; $display("FAIL busy_result: got %b/%0d want 1/%0d", d, result, ex.res); end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || error) extra++;
    end
    n_vec++; if (extra !== 0) begin n_bad++; $display("FAIL busy_queued: got %0d extra outputs want 0", extra); end
    launch(16'd0, 16'd4);
    wait_out(cyc, d, e);
    ex = sb.pop_front();
    n_vec++; if (d !== 1'b1 || result !== ex.res || result !== 16'd8) begin n_bad++; $display("FAIL busy_coef: got %b/%0d want 1/%0d", d, result, ex.res); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc, extra;
    logic d, e;
    exp_t ex;
    launch(16'd0, 16'd20);
    repeat (8) @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_running: got busy %b want 1", busy); end
    rst = 1'b1;
    #1;
    n_vec++; if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || ovf !== 1'b0) begin n_bad++; $display("FAIL mid_reset: got %b%b/%h/%b want 00/0/0", busy, done, result, ovf); end
    sb.delete();
    m_res = '0;
    m_ovf = 1'b0;
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    n_vec++; if (extra !== 0) begin n_bad++; $display("FAIL mid_no_done: got %0d active cycles want 0", extra); end
    set_coef(0, 16'd1);
    set_coef(2, 16'd3);
    launch(16'd1, 16'd6);
    wait_out(cyc, d, e);
    ex = sb.pop_front();
    n_vec++; if (d !== 1'b1 || result !== ex.res || ovf !== ex.ovf) begin n_bad++; $display("FAIL mid_rerun: got %b/%0d/%b want 1/%0d/%b", d, result, ovf, ex.res, ex.ovf); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_linear();
    test_odd();
    test_trap_reuse();
    test_error();
    test_ovf();
    test_max_limit();
    test_busy_ignore();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/simpson_poly_integrator.md
Name: simpson_poly_integrator

Overview:
- Parametrised successor to the push-button Simpson integrator FSM.
- Integrates an unsigned polynomial of configurable degree over integer limits [a,b] with unit step.
- Uses Simpson panels plus a single trapezoid panel when the interval count is odd.
- Word-level handshake, an exact single final divide, overflow and error flags.
- Sits between the input front end (debouncers/switch registers) and the display driver.

Parameters:
W, 16, data width of coefficients, limits and result
DEG, 3, polynomial degree; DEG+1 coefficients c[0..DEG], f(x)=sum c[i]*x^i
ACC_W, 48, internal evaluation/accumulator width; all internal arithmetic wraps modulo 2^ACC_W
CI_W, $clog2(DEG+1) (min 1), coefficient index width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
coef_we  in  1  write coef_data to c[coef_idx]; ignored while busy=1 or coef_idx>DEG
coef_idx  in  CI_W  coefficient index
coef_data  in  W  coefficient value (unsigned)
start  in  1  one-cycle request; samples a and b; ignored while busy=1
a  in  W  left limit (unsigned)
b  in  W  right limit (unsigned)
busy  out  1  high from the cycle after an accepted start until done or error
done  out  1  one-cycle pulse; result and ovf valid
error  out  1  one-cycle pulse when a>=b; result and ovf unchanged
result  out  W  low W bits of N/6, held until next done
ovf  out  1  1 if N/6 >= 2^W, held with result

Behaviour:
- Reset (async, any state): state=IDLE; all coefficients 0; busy, done, error, ovf = 0; result=0. Reset mid-integration abandons the run; no done is produced.
- Coefficient writes: take effect at the clock edge; a write in the same cycle as start is applied before evaluation begins.
- Evaluator:
  - Horner form: acc=c[DEG], then DEG iterations of acc=acc*x+c[i], i=DEG-1..0.
  - Latency L=DEG+1 cycles from eval_start to eval_done.
  - x is zero-extended to ACC_W.
- Accumulator N: ACC_W bits, cleared on accepted start.
  - Panel weights, scaled by 6 so only one divide is needed:
  - Simpson panel [p,p+2]: N += 2*(f(p)+4f(p+1)+f(p+2)).
  - Trapezoid [b-1,b]: N += 3*(f(b-1)+f(b)).
- FSM states:
  - IDLE: on start, latch a,b; clear N; go to CHECK.
  - CHECK: if a>=b, go to ERR. Else if (b-a) is odd, go to TRAP (nodes b-1, b) and set hi=b-1. Otherwise hi=b and go to PANEL.
  - TRAP: evaluate f(b-1) then f(b) sequentially; add the trapezoid term; go to PANEL.
  - PANEL: if p==hi, go to FIN. Else evaluate the required nodes, add the Simpson term, set p=p+2, and loop.
    - p starts at a.
    - f(p+2) is retained and reused as the next panel's f(p), so every panel after the first costs 2 evaluations.
    - The first panel costs 3 evaluations.
  - FIN: result=N/6 [W-1:0]; ovf=|(N/6)>>W; done=1 for 1 cycle; back to IDLE.
  - ERR: error=1 for 1 cycle; back to IDLE.
- Latency (even, k=(b-a)/2 panels): 1 (CHECK) + (2k+1)*L + k (accumulate cycles) + 1 (FIN), measured from start to done. Odd case adds 2L+1 for TRAP. The bench checks the exact count for DEG=3.
- Limit arithmetic: b-1 and p+2 never wrap, because a<b guarantees p<=hi<=b.
- Boundary b-a=1: TRAP only, zero panels.
- Boundary b=2^W-1: legal; nodes are zero-extended.
- start while busy: ignored, no queueing.

Decomposition:
- Shared package simpson_pkg:
  - FSM state encoding (IDLE, CHECK, TRAP, PANEL, FIN, ERR);
  - weight constants SIMP_END=2, SIMP_MID=8, TRAP_W=3, NORM=6;
  - default W/DEG/ACC_W.
- Sub-module poly_horner_eval (DEG, W, ACC_W):
  - inputs clk, rst, coef vector, x, eval_start;
  - outputs eval_done pulse and y.
  - Reused later by other quadrature blocks.
- Divide by the NORM constant is combinational in FIN.

Test Plan:
- f(x)=x (c1=1, others 0), a=0, b=2 -> N=12, done pulse with result=2, ovf=0; done exactly 1+3*4+1+1=15 cycles after start (DEG=3).
- f(x)=x^2 (c2=1), a=0, b=3 (odd) -> trapezoid 39 plus panel 16, N=55, result=9, ovf=0.
- f(x)=5 (c0=5), a=10, b=11 -> TRAP only, result=5; then a=10, b=14 -> result=20, with panel endpoint reuse confirmed by counting eval_start pulses = 5.
- a=4, b=4, then a=7, b=3 -> error pulse each time, busy returns to 0, and result/ovf keep the prior values.
- c0=0xFFFF, a=0, b=2 -> N/6=131070, result=0xFFFE, ovf=1.
- rst asserted mid-PANEL -> outputs 0 immediately with no done; coef_we and a second start while busy are ignored; next run with reloaded coefficients is correct.
